// File: rtl/ui_sprite_compositor.sv
// rtl/ui_sprite_compositor.sv - double-buffered overlay sprite table with 2-stage hit/priority/address pipeline
module ui_sprite_compositor #(
  parameter int NUM_SLOTS   = 8,
  parameter int ATLAS_W     = 360,
  parameter int ATLAS_DEPTH = 86400,
  parameter int ADDR_W      = 17,
  parameter int SCALE_SHIFT = 1,
  parameter int BLINK_BIT   = 4,
  localparam int SLOT_W     = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [9:0]        h_cnt,
  input  logic [9:0]        v_cnt,
  input  logic              frame_start,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [SLOT_W-1:0] cfg_slot,
  input  logic              cfg_en,
  input  logic              cfg_blink,
  input  logic [8:0]        cfg_x,
  input  logic [8:0]        cfg_y,
  input  logic [8:0]        cfg_w,
  input  logic [8:0]        cfg_h,
  input  logic [8:0]        cfg_src_x,
  input  logic [8:0]        cfg_src_y,
  output logic [ADDR_W-1:0] pixel_addr,
  output logic              isObject,
  output logic [SLOT_W-1:0] hit_slot
);

  typedef struct packed {
    logic       en;
    logic       blink;
    logic [8:0] x;
    logic [8:0] y;
    logic [8:0] w;
    logic [8:0] h;
    logic [8:0] src_x;
    logic [8:0] src_y;
  } slot_t;

  slot_t       shadow_q [NUM_SLOTS];
  slot_t       active_q [NUM_SLOTS];
  logic        ready_q;
  logic [7:0]  frame_cnt;
  logic        cfg_fire;

  logic [9:0]  lx;
  logic [9:0]  ly;

  // stage 1: per-slot hit flags and atlas column/row of the current pixel
  logic [NUM_SLOTS-1:0] hit_c;
  logic [10:0]          col_c [NUM_SLOTS];
  logic [10:0]          row_c [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] hit_q;
  logic [10:0]          col_q [NUM_SLOTS];
  logic [10:0]          row_q [NUM_SLOTS];

  // stage 2: priority winner and its linear atlas address
  logic              any_hit;
  logic [SLOT_W-1:0] sel_slot;
  logic [10:0]       sel_col;
  logic [10:0]       sel_row;
  logic [31:0]       addr_full;
  logic [ADDR_W-1:0] addr_mod;

  // ready drops for the commit cycle so shadow writes never race the copy
  assign cfg_ready = ready_q & ~frame_start;
  assign cfg_fire  = cfg_valid & cfg_ready;

  assign lx = h_cnt >> SCALE_SHIFT;
  assign ly = v_cnt >> SCALE_SHIFT;

  // slot tables: shadow takes host writes, active is refreshed at frame start
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ready_q   <= 1'b0;
      frame_cnt <= 8'd0;
      for (int s = 0; s < NUM_SLOTS; s++) begin
        shadow_q[s] <= '0;
        active_q[s] <= '0;
      end
    end else begin
      ready_q <= 1'b1;
      if (frame_start) begin
        frame_cnt <= frame_cnt + 8'd1;
        for (int s = 0; s < NUM_SLOTS; s++) begin
          active_q[s] <= shadow_q[s];
        end
      end
      if (cfg_fire && (int'(cfg_slot) < NUM_SLOTS)) begin
        shadow_q[cfg_slot] <= {cfg_en, cfg_blink, cfg_x, cfg_y, cfg_w, cfg_h,
                               cfg_src_x, cfg_src_y};
      end
    end
  end

  // per-slot window test; bounds are 10 bits wide so x+w never wraps
  always_comb begin
    for (int s = 0; s < NUM_SLOTS; s++) begin
      hit_c[s] = active_q[s].en
              && !(active_q[s].blink && frame_cnt[BLINK_BIT])
              && (lx >= {1'b0, active_q[s].x})
              && (lx <  ({1'b0, active_q[s].x} + {1'b0, active_q[s].w}))
              && (ly >= {1'b0, active_q[s].y})
              && (ly <  ({1'b0, active_q[s].y} + {1'b0, active_q[s].h}));
      col_c[s] = 11'(lx) - 11'(active_q[s].x) + 11'(active_q[s].src_x);
      row_c[s] = 11'(ly) - 11'(active_q[s].y) + 11'(active_q[s].src_y);
    end
  end

  // stage 1 register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hit_q <= '0;
      for (int s = 0; s < NUM_SLOTS; s++) begin
        col_q[s] <= '0;
        row_q[s] <= '0;
      end
    end else begin
      hit_q <= hit_c;
      for (int s = 0; s < NUM_SLOTS; s++) begin
        col_q[s] <= col_c[s];
        row_q[s] <= row_c[s];
      end
    end
  end

  // priority pick: scan high to low so the lowest hitting index is kept
  always_comb begin
    any_hit  = 1'b0;
    sel_slot = '0;
    sel_col  = '0;
    sel_row  = '0;
    for (int s = NUM_SLOTS - 1; s >= 0; s--) begin
      if (hit_q[s]) begin
        any_hit  = 1'b1;
        sel_slot = SLOT_W'(s);
        sel_col  = col_q[s];
        sel_row  = row_q[s];
      end
    end
    addr_full = 32'(sel_col) + 32'(sel_row) * 32'(ATLAS_W);
    addr_mod  = ADDR_W'(addr_full % 32'(ATLAS_DEPTH));
  end

  // stage 2 register: outputs are forced to zero when nothing hits
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      isObject   <= 1'b0;
      hit_slot   <= '0;
      pixel_addr <= '0;
    end else begin
      isObject   <= any_hit;
      hit_slot   <= any_hit ? sel_slot : '0;
      pixel_addr <= any_hit ? addr_mod : '0;
    end
  end

endmodule

// File: tb/tb_ui_sprite_compositor.sv
// tb/tb_ui_sprite_compositor.sv - scoreboard bench for ui_sprite_compositor
module tb_ui_sprite_compositor;

  localparam int SW = 3;
  localparam int AW = 17;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [9:0]    h_cnt, v_cnt;
  logic          frame_start, cfg_valid, cfg_ready;
  logic [SW-1:0] cfg_slot;
  logic          cfg_en, cfg_blink;
  logic [8:0]    cfg_x, cfg_y, cfg_w, cfg_h, cfg_src_x, cfg_src_y;
  logic [AW-1:0] pixel_addr;
  logic          isObject;
  logic [SW-1:0] hit_slot;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int fc = 0;
  int probe_id = 0;

  typedef struct {
    int            due;
    logic          obj;
    logic [SW-1:0] slot;
    logic [AW-1:0] addr;
    int            id;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  ui_sprite_compositor dut (
    .clk(clk), .rst_n(rst_n), .h_cnt(h_cnt), .v_cnt(v_cnt),
    .frame_start(frame_start), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_slot(cfg_slot), .cfg_en(cfg_en), .cfg_blink(cfg_blink),
    .cfg_x(cfg_x), .cfg_y(cfg_y), .cfg_w(cfg_w), .cfg_h(cfg_h),
    .cfg_src_x(cfg_src_x), .cfg_src_y(cfg_src_y),
    .pixel_addr(pixel_addr), .isObject(isObject), .hit_slot(hit_slot)
  );

  always #5 clk = ~clk;

  // count rising edges so expected entries can be scheduled by cycle
  always @(posedge clk) cyc = cyc + 1;

  // monitor: compare the DUT outputs against the entry due this cycle
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due < cyc) begin
      e = sb.pop_front();
      vectors++;
      miscompares++;
      $display("FAIL probe%0d: output never sampled (due cycle %0d)", e.id, e.due);
    end
    if (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      vectors++;
      if (isObject !== e.obj || hit_slot !== e.slot || pixel_addr !== e.addr) begin
        miscompares++;
        $display("FAIL probe%0d: got isObject=%0b hit_slot=%0d pixel_addr=%0d, expected isObject=%0b hit_slot=%0d pixel_addr=%0d",
                 e.id, isObject, hit_slot, pixel_addr, e.obj, e.slot, e.addr);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic write_slot(input int s, input int en, input int bl, input int x, input int y,
                            input int w, input int h, input int sx, input int sy);
    logic rdy;
    logic done;
    done = 1'b0;
    cfg_valid = 1'b1;
    cfg_slot = SW'(s);
    cfg_en = 1'(en);
    cfg_blink = 1'(bl);
    cfg_x = 9'(x); cfg_y = 9'(y); cfg_w = 9'(w); cfg_h = 9'(h);
    cfg_src_x = 9'(sx); cfg_src_y = 9'(sy);
    for (int t = 0; t < 10 && !done; t++) begin
      #1;
      rdy = cfg_ready;
      @(negedge clk);
      if (rdy) done = 1'b1;
    end
    cfg_valid = 1'b0;
    if (!done) chk("write_timeout", 32'(done), 32'd1);
  endtask

  task automatic pulse_frame();
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    fc = (fc + 1) % 256;
  endtask

  task automatic probe(input int h, input int v, input int obj, input int slot, input int addr);
    h_cnt = 10'(h);
    v_cnt = 10'(v);
    probe_id++;
    sb.push_back('{due: cyc + 2, obj: 1'(obj), slot: SW'(slot), addr: AW'(addr), id: probe_id});
    @(negedge clk);
  endtask

  task automatic drain();
    for (int t = 0; t < 20 && sb.size() > 0; t++) @(negedge clk);
    chk("drain", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; h_cnt = 10'd1023; v_cnt = 10'd1023;
    frame_start = 1'b0; cfg_valid = 1'b0; cfg_slot = '0;
    cfg_en = 1'b0; cfg_blink = 1'b0;
    cfg_x = '0; cfg_y = '0; cfg_w = '0; cfg_h = '0; cfg_src_x = '0; cfg_src_y = '0;
    repeat (3) @(negedge clk);
    chk("reset_ready", 32'(cfg_ready), 32'd0);
    chk("reset_isObject", 32'(isObject), 32'd0);
    chk("reset_addr", 32'(pixel_addr), 32'd0);
    chk("reset_slot", 32'(hit_slot), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", 32'(cfg_ready), 32'd1);

    // shadow write invisible until commit, then basic hit and window edges
    write_slot(0, 1, 0, 120, 120, 80, 20, 0, 40);
    probe(250, 250, 0, 0, 0);
    pulse_frame();
    probe(250, 250, 1, 0, 16205);
    probe(251, 251, 1, 0, 16205);
    probe(240, 240, 1, 0, 14400);
    probe(398, 278, 1, 0, 21319);
    probe(400, 250, 0, 0, 0);
    probe(250, 280, 0, 0, 0);
    probe(238, 250, 0, 0, 0);

    // overlap priority, then lower slot disabled
    write_slot(2, 1, 0, 5, 5, 10, 10, 0, 0);
    write_slot(5, 1, 0, 0, 0, 20, 20, 100, 2);
    probe(20, 20, 0, 0, 0);
    pulse_frame();
    probe(20, 20, 1, 2, 1805);
    write_slot(2, 0, 0, 5, 5, 10, 10, 0, 0);
    pulse_frame();
    probe(20, 20, 1, 5, 4430);

    // address modulo, right edge, zero width
    write_slot(1, 1, 0, 300, 200, 10, 4, 350, 239);
    write_slot(3, 1, 0, 50, 50, 0, 5, 0, 0);
    pulse_frame();
    probe(610, 402, 1, 1, 355);
    probe(618, 402, 1, 1, 359);
    probe(620, 402, 0, 0, 0);
    probe(100, 100, 0, 0, 0);

    // last write to a slot within a frame wins
    write_slot(4, 1, 0, 400, 400, 4, 4, 0, 0);
    write_slot(4, 1, 0, 450, 450, 4, 4, 0, 0);
    pulse_frame();
    probe(800, 800, 0, 0, 0);
    probe(902, 904, 1, 4, 721);

    // cfg_valid held across frame_start: stalled one cycle, committed a frame later
    frame_start = 1'b1;
    cfg_valid = 1'b1; cfg_slot = SW'(6); cfg_en = 1'b1; cfg_blink = 1'b0;
    cfg_x = 9'd30; cfg_y = 9'd300; cfg_w = 9'd5; cfg_h = 9'd5; cfg_src_x = 9'd0; cfg_src_y = 9'd0;
    #1 chk("ready_during_frame_start", 32'(cfg_ready), 32'd0);
    @(negedge clk);
    frame_start = 1'b0;
    fc = (fc + 1) % 256;
    #1 chk("ready_after_frame_start", 32'(cfg_ready), 32'd1);
    @(negedge clk);
    cfg_valid = 1'b0;
    probe(62, 602, 0, 0, 0);
    pulse_frame();
    probe(62, 602, 1, 6, 361);

    // blink slot across a full frame-counter wrap
    write_slot(7, 1, 1, 40, 40, 2, 2, 0, 0);
    pulse_frame();
    for (int k = 0; k < 260; k++) begin
      if (((fc >> 4) & 1) == 0) probe(80, 80, 1, 7, 0);
      else probe(80, 80, 0, 0, 0);
      pulse_frame();
    end
    drain();

    // mid-frame reset wipes active, pending shadow and frame counter
    while (((fc >> 4) & 1) == 0) pulse_frame();
    write_slot(3, 1, 0, 60, 60, 4, 4, 0, 0);
    probe(250, 250, 1, 0, 16205);
    drain();
    rst_n = 1'b0;
    @(negedge clk);
    chk("midreset_isObject", 32'(isObject), 32'd0);
    chk("midreset_addr", 32'(pixel_addr), 32'd0);
    chk("midreset_ready", 32'(cfg_ready), 32'd0);
    rst_n = 1'b1;
    fc = 0;
    @(negedge clk);
    pulse_frame();
    probe(250, 250, 0, 0, 0);
    probe(120, 120, 0, 0, 0);
    write_slot(7, 1, 1, 40, 40, 2, 2, 0, 0);
    pulse_frame();
    probe(80, 80, 1, 7, 0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
